// File: rtl/axis_ser_pkg.sv
// Shared types and helpers for the AXI-Stream width-down serializer.
package axis_ser_pkg;

    // Widest keep mask keep_len() understands; callers zero-extend narrower masks.
    localparam int unsigned KEEP_MAX  = 32;
    localparam int unsigned LEN_MAX_W = 6;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Number of lanes to emit: index of the top set keep bit plus one, 0 when empty.
    function automatic logic [LEN_MAX_W-1:0] keep_len(input logic [KEEP_MAX-1:0] keep);
        logic [LEN_MAX_W-1:0] len;
        len = '0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            if (keep[i]) begin
                len = LEN_MAX_W'(i + 1);
            end
        end
        return len;
    endfunction

endpackage

// File: rtl/axis_serializer.sv
// AXI-Stream width-down serializer: accepts one K-lane word, emits its lanes
// least-significant first as N-bit beats.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   s_tdata/tkeep/tlast word payload; s_tvalid/s_tready word handshake
//   m_tdata/tlast       registered output beat; m_tvalid/m_tready beat handshake
//   err_keep            sticky flag, set when an all-zero keep word is accepted
module axis_serializer
    import axis_ser_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned K = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N*K-1:0] s_tdata,
    input  logic [K-1:0] s_tkeep,
    input  logic         s_tlast,
    input  logic         s_tvalid,
    output logic         s_tready,
    output logic [N-1:0] m_tdata,
    output logic         m_tlast,
    output logic         m_tvalid,
    input  logic         m_tready,
    output logic         err_keep
);

    localparam int unsigned W     = N * K;
    localparam int unsigned IDX_W = $clog2(K);
    localparam int unsigned LEN_W = $clog2(K + 1);

    state_t             state_q, state_d;
    logic [W-1:0]       hold_q, hold_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               last_q, last_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               err_q, err_d;
    logic [N-1:0]       m_tdata_q, m_tdata_d;
    logic               m_tlast_q, m_tlast_d;
    logic               m_tvalid_q, m_tvalid_d;

    logic [IDX_W-1:0]   last_idx;
    logic               at_last;
    logic               accept;
    logic               beat;
    logic [LEN_W-1:0]   new_len;

    // len_q is at least 1 whenever SEND is active, so the wrap at len 0 is never used.
    assign last_idx = IDX_W'(len_q - LEN_W'(1));
    assign at_last  = (state_q == SEND) && (idx_q == last_idx);
    // Ready for a new word while empty, or while the final beat is leaving this cycle.
    assign s_tready = !reset && ((state_q == IDLE) || (at_last && m_tready));
    assign accept   = s_tvalid && s_tready;
    assign beat     = (state_q == SEND) && m_tready;
    assign new_len  = LEN_W'(keep_len(KEEP_MAX'(s_tkeep)));

    // Next-state, holding register and next output beat.
    always_comb begin
        logic load;
        load     = 1'b0;
        state_d  = state_q;
        hold_d   = hold_q;
        len_d    = len_q;
        last_d   = last_q;
        idx_d    = idx_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    load = 1'b1;
                end
            end
            SEND: begin
                if (beat) begin
                    if (!at_last) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            hold_d = s_tdata;
            len_d  = new_len;
            last_d = s_tlast;
            idx_d  = '0;
            // An empty keep word is swallowed: no beats, flag it.
            if (new_len == '0) begin
                state_d = IDLE;
                err_d   = 1'b1;
            end else begin
                state_d = SEND;
            end
        end

        m_tvalid_d = (state_d == SEND);
        m_tdata_d  = hold_d[idx_d*N +: N];
        m_tlast_d  = (state_d == SEND) && last_d && (idx_d == IDX_W'(len_d - LEN_W'(1)));
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            len_q      <= '0;
            last_q     <= 1'b0;
            idx_q      <= '0;
            err_q      <= 1'b0;
            m_tdata_q  <= '0;
            m_tlast_q  <= 1'b0;
            m_tvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            len_q      <= len_d;
            last_q     <= last_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            m_tdata_q  <= m_tdata_d;
            m_tlast_q  <= m_tlast_d;
            m_tvalid_q <= m_tvalid_d;
        end
    end

    assign m_tdata  = m_tdata_q;
    assign m_tlast  = m_tlast_q;
    assign m_tvalid = m_tvalid_q;
    assign err_keep = err_q;

endmodule

// File: tb/tb_axis_serializer.sv
// Directed self-checking bench for axis_serializer (N=8, K=4).
module tb_axis_serializer;

    localparam int unsigned N = 8;
    localparam int unsigned K = 4;

    logic           clk;
    logic           reset;
    logic [N*K-1:0] s_tdata;
    logic [K-1:0]   s_tkeep;
    logic           s_tlast;
    logic           s_tvalid;
    logic           s_tready;
    logic [N-1:0]   m_tdata;
    logic           m_tlast;
    logic           m_tvalid;
    logic           m_tready;
    logic           err_keep;

    axis_serializer #(.N(N), .K(K)) dut (
        .clk      (clk),
        .reset    (reset),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tlast  (s_tlast),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tlast  (m_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .err_keep (err_keep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Beat log entries are {tlast, tdata}.
    logic [8:0] beat_q[$];
    int         beat_cyc[$];
    int         acc_cyc[$];
    int         valid_cnt = 0;
    int         cyc = 0;

    // Inputs change just after posedge, so negedge shows what the next edge will do.
    always @(negedge clk) begin
        if (m_tvalid && m_tready) begin
            beat_q.push_back({m_tlast, m_tdata});
            beat_cyc.push_back(cyc);
        end
        if (s_tvalid && s_tready) begin
            acc_cyc.push_back(cyc);
        end
        if (m_tvalid) begin
            valid_cnt++;
        end
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        beat_q.delete();
        beat_cyc.delete();
        acc_cyc.delete();
        valid_cnt = 0;
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, input bit hold_valid);
        bit got;
        got      = 1'b0;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_tready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("send_timeout", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        if (!hold_valid) s_tvalid = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        for (int i = 0; i < 100 && beat_q.size() < n; i++) begin
            @(posedge clk);
        end
        #1;
        if (beat_q.size() < n) check("beat_timeout", 32'(beat_q.size()), 32'(n));
    endtask

    task automatic check_seq(input string tag, input logic [8:0] exp[8], input int n);
        for (int i = 0; i < n; i++) begin
            if (i < beat_q.size())
                check($sformatf("%s[%0d]", tag, i), 32'(beat_q[i]), 32'(exp[i]));
            else
                check($sformatf("%s[%0d]_missing", tag, i), 32'hFFFF_FFFF, 32'(exp[i]));
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_tready", 32'(s_tready), 32'd0);
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_m_tlast",  32'(m_tlast),  32'd0);
        check("rst_m_tdata",  32'(m_tdata),  32'd0);
        check("rst_err_keep", 32'(err_keep), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_s_tready", 32'(s_tready), 32'd1);
        check("post_rst_m_tvalid", 32'(m_tvalid), 32'd0);
        @(posedge clk);
        #1;

        // Full word
        clear_log();
        send(32'h4433_2211, 4'b1111, 1'b1, 1'b0);
        wait_beats(4);
        check_seq("full", '{9'h011, 9'h022, 9'h033, 9'h144, 9'h0, 9'h0, 9'h0, 9'h0}, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < beat_cyc.size() && acc_cyc.size() > 0)
                check($sformatf("full_cyc[%0d]", i), 32'(beat_cyc[i] - acc_cyc[0]), 32'(i + 1));
        end
        idle_cycles(2);

        // Back-to-back words, s_tvalid held high
        clear_log();
        send(32'h4433_2211, 4'b1111, 1'b0, 1'b1);
        send(32'h8877_6655, 4'b1111, 1'b1, 1'b0);
        wait_beats(8);
        check_seq("b2b", '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055, 9'h066, 9'h077, 9'h188}, 8);
        if (beat_cyc.size() >= 8)
            check("b2b_no_gap", 32'(beat_cyc[7] - beat_cyc[0]), 32'd7);
        if (beat_cyc.size() >= 4 && acc_cyc.size() >= 2)
            check("b2b_accept_on_0x44", 32'(acc_cyc[1]), 32'(beat_cyc[3]));
        idle_cycles(2);

        // Partial keep: 0011 then 0101 (hole in lane 1 still emitted)
        clear_log();
        send(32'hDDCC_BBAA, 4'b0011, 1'b1, 1'b0);
        wait_beats(2);
        idle_cycles(3);
        check("keep0011_count", 32'(beat_q.size()), 32'd2);
        check_seq("keep0011", '{9'h0AA, 9'h1BB, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0}, 2);
        clear_log();
        send(32'hDDCC_BBAA, 4'b0101, 1'b1, 1'b0);
        wait_beats(3);
        idle_cycles(3);
        check("keep0101_count", 32'(beat_q.size()), 32'd3);
        check_seq("keep0101", '{9'h0AA, 9'h0BB, 9'h1CC, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0}, 3);

        // Backpressure while 0x22 is presented
        clear_log();
        send(32'h4433_2211, 4'b1111, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        m_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("bp_data[%0d]", i),    32'(m_tdata),  32'h22);
            check($sformatf("bp_valid[%0d]", i),   32'(m_tvalid), 32'd1);
            check($sformatf("bp_s_tready[%0d]", i), 32'(s_tready), 32'd0);
        end
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        wait_beats(4);
        check_seq("bp", '{9'h011, 9'h022, 9'h033, 9'h144, 9'h0, 9'h0, 9'h0, 9'h0}, 4);
        idle_cycles(2);

        // Empty keep word is consumed silently and flags err_keep
        clear_log();
        send(32'h1234_5678, 4'b0000, 1'b1, 1'b0);
        idle_cycles(4);
        check("empty_accepted", 32'(acc_cyc.size()), 32'd1);
        check("empty_no_valid", 32'(valid_cnt), 32'd0);
        check("empty_err_keep", 32'(err_keep), 32'd1);
        clear_log();
        send(32'h0000_00AB, 4'b0001, 1'b0, 1'b0);
        wait_beats(1);
        idle_cycles(2);
        check_seq("after_empty", '{9'h0AB, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0}, 1);
        check("err_keep_sticky", 32'(err_keep), 32'd1);

        // Reset mid-word after 0x22 handshakes
        clear_log();
        send(32'h4433_2211, 4'b1111, 1'b1, 1'b0);
        wait_beats(2);
        reset    = 1'b1;
        m_tready = 1'b0;
        @(negedge clk);
        check("midrst_s_tready", 32'(s_tready), 32'd0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        m_tready = 1'b1;
        @(negedge clk);
        check("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("midrst_err_keep", 32'(err_keep), 32'd0);
        check("midrst_s_tready_after", 32'(s_tready), 32'd1);
        idle_cycles(4);
        check("midrst_no_more_beats", 32'(beat_q.size()), 32'd2);
        clear_log();
        send(32'h8877_6655, 4'b1111, 1'b1, 1'b0);
        wait_beats(4);
        check_seq("post_midrst", '{9'h055, 9'h066, 9'h077, 9'h188, 9'h0, 9'h0, 9'h0, 9'h0}, 4);
        idle_cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_serializer.md
# axis_serializer

AXI-Stream width-down serializer that sits directly upstream of the `axis_reg` register slice. It accepts one wide word of `K` lanes per handshake, then emits the lanes one at a time as `N`-bit beats into `axis_reg`'s slave port. Emission runs least-significant lane first. `m_tlast` marks the final beat of a word that arrived with `s_tlast` set. The block converts bus-width words from the processing side into the byte stream that `axis_reg` and the downstream sink consume.

## Interface
- `N`, 8: output beat width in bits; matches `axis_reg` `N`.
- `K`, 4: lanes per input word, K ≥ 2; input width is `N*K`.

- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high. Sampled on the `clk` rising edge.
- `s_tdata`  in  N*K: input word; lane i is bits [N*i+N-1 : N*i].
- `s_tkeep`  in  K: lane-valid mask. The beat count is taken from the highest set bit.
- `s_tlast`  in  1: frame end; applies to the word's final emitted beat.
- `s_tvalid`  in  1: input word valid.
- `s_tready`  out  1: block can accept a word this cycle.
- `m_tdata`  out  N: output beat; connects to `axis_reg` `s_tdata`.
- `m_tlast`  out  1: connects to `axis_reg` `s_tlast`.
- `m_tvalid`  out  1: output beat valid.
- `m_tready`  in  1: downstream ready.
- `err_keep`  out  1: sticky flag; set when a word with `s_tkeep == 0` is accepted.

## Operation
- **States.**
  - IDLE: holding register empty.
  - SEND: holding register loaded; `m_tvalid`=1.
- **Accept.** A word is accepted when `s_tvalid & s_tready`. On accept:
  - latch `s_tdata` into the holding register;
  - set `len` = (index of the most-significant set bit of `s_tkeep`) + 1;
  - latch `s_tlast`;
  - clear the beat counter `idx` to 0.
- **Lane selection by `len`.**
  - Lanes below the top set bit are emitted even if their keep bit is 0. Holes are not skipped.
  - Lanes above the top set bit are never emitted.
- **Empty keep.** A word with `s_tkeep == 0` is consumed without emitting any beat. Its `s_tlast` is discarded, `err_keep` is set, and the state stays or returns to IDLE.
- **Outputs in SEND.**
  - `m_tdata` = lane `idx` of the holding register.
  - `m_tlast` = (`idx == len-1`) & latched `s_tlast`.
- **Beat handshake** (`m_tvalid & m_tready`):
  - if `idx < len-1`: `idx` increments;
  - else, if a new word is accepted in the same cycle: load it and stay in SEND (or go to IDLE if its keep is 0);
  - else: go to IDLE.
- **`s_tready`** = `!reset & (IDLE | (SEND & idx==len-1 & m_tready))`. This is combinational from `m_tready` and allows back-to-back words with no bubble.
- **`idx` width.** `idx` is `$clog2(K)` bits. It never wraps past `len-1`.

## Timing
- **Reset values.** While `reset` is high and on the cycle after:
  - state = IDLE, `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, `idx`=0, `err_keep`=0;
  - `s_tready`=0 while `reset`=1, and 1 on the first cycle after release.
- **Latency.** A word accepted at edge t presents beat 0 with `m_tvalid`=1 after edge t. It is visible in cycle t+1. Beats are registered; there is no combinational path from `s_*` to `m_*`.
- **Throughput.** One beat per cycle while `m_tready`=1. A full-keep word takes K cycles, and consecutive words stream with no idle cycle.
- **Backpressure.** While `m_tvalid & !m_tready`, `m_tdata` and `m_tlast` hold stable and `m_tvalid` stays 1 (AXIS rule). `s_tready` stays 0 during backpressure in SEND.
- **Reset mid-word.** The held word is dropped and emits no further beats. `m_tvalid` drops after the reset edge.
- **Inputs while `s_tready`=0.** `s_tdata`, `s_tkeep` and `s_tlast` are ignored.

## Structure
- **Package `axis_ser_pkg`:**
  - state enum {IDLE, SEND};
  - function `keep_len(keep)`, returning (top set bit + 1), or 0 for an empty mask.
- **Single module, no sub-modules.** The lane mux is `holding[idx*N +: N]`.

## Test plan
All scenarios use N=8, K=4.
- **Full word.** After reset, send `s_tdata`=0x44332211, `s_tkeep`=4'b1111, `s_tlast`=1, with `m_tready` held 1.
  - Required: beats 0x11, 0x22, 0x33, 0x44 in consecutive cycles starting one cycle after accept.
  - Required: `m_tlast`=1 only on 0x44.
- **Back-to-back.** Send two words 0x44332211 (`s_tlast`=0) and 0x88776655 (`s_tlast`=1) with `s_tvalid` held high.
  - Required: 8 consecutive beats 0x11..0x88 with no gap.
  - Required: the second word is accepted on the cycle beat 0x44 handshakes.
  - Required: `m_tlast` is set only on 0x88.
- **Partial keep.** Send `s_tkeep`=4'b0011 with data 0xDDCCBBAA and `s_tlast`=1.
  - Required: beats 0xAA, then 0xBB with `m_tlast`=1.
  - Required: next, `s_tkeep`=4'b0101 → 3 beats 0xAA, 0xBB, 0xCC.
- **Backpressure.** Pull `m_tready` low for 3 cycles while beat 0x22 is presented.
  - Required: 0x22 and `m_tvalid` hold stable and `s_tready`=0.
  - Required: the sequence resumes intact once `m_tready` returns.
- **Empty keep.** Send `s_tkeep`=0 with `s_tlast`=1.
  - Required: `s_tready` handshake occurs, no `m_tvalid`, `err_keep`=1 and held until reset.
- **Reset mid-word.** Assert `reset` for 1 cycle after beat 0x22.
  - Required: `m_tvalid`=0 next cycle, `err_keep`=0, and no further beats of that word.
  - Required: a fresh word then serializes normally.
